dma_mem_responder: RTL

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

---
 rtl/matrix_pkg.sv | 19 +
 rtl/sp_ram.sv | 26 ++
 rtl/dma_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared FSM state type, wait-counter width and memory map
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // Default placement of the accelerator operand/result matrices
    localparam logic [31:0] A_BASE = 32'h0000_1000;
    localparam logic [31:0] B_BASE = 32'h0000_2000;
    localparam logic [31:0] C_BASE = 32'h0000_3000;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port word RAM, synchronous read, no reset on contents
module sp_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - DMA / Wishbone responder sharing one word memory
module dma_mem_responder
    import matrix_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_last_wb;
    logic                  r_grant_wb;
    logic                  r_we;
    logic                  r_valid;
    logic [AW-1:0]         r_idx;
    logic [31:0]           r_wdata;
    logic                  r_dma_ack;
    logic                  r_dma_err;
    logic [31:0]           r_dma_rdata;
    logic                  r_wb_ack;
    logic [31:0]           r_wb_dat;

    logic          w_grant_wb;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_req_held;
    logic          w_ram_we;
    logic          w_ram_re;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_rd_value;

    // Round-robin: a lone requester always wins; on a tie the one not served last wins
    assign w_grant_wb = wb_stb_i && (!dma_req || !r_last_wb);
    assign w_sel_addr = w_grant_wb ? wb_adr_i : dma_addr;
    assign w_offset   = w_sel_addr - BASE_ADDR;
    assign w_in_range = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr >= BASE_ADDR)
                        && ({1'b0, w_offset} < SPAN);
    assign w_idx      = w_in_range ? w_offset[AW+1:2] : '0;

    assign w_req_held = r_grant_wb ? wb_stb_i : dma_req;
    assign w_ram_we   = (r_state == ST_ACK) && w_req_held && r_we && r_valid;
    assign w_ram_re   = (r_state == ST_ACCESS);
    assign w_rd_value = (r_valid && !r_we) ? w_ram_rdata : 32'h0;

    sp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_re   (w_ram_re),
        .i_addr (r_idx),
        .i_wdata(r_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_last_wb   <= 1'b1;
            r_grant_wb  <= 1'b0;
            r_we        <= 1'b0;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_dma_ack   <= 1'b0;
            r_dma_err   <= 1'b0;
            r_dma_rdata <= '0;
            r_wb_ack    <= 1'b0;
            r_wb_dat    <= '0;
        end else begin
            r_dma_ack   <= 1'b0;
            r_dma_err   <= 1'b0;
            r_dma_rdata <= '0;
            r_wb_ack    <= 1'b0;
            r_wb_dat    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (dma_req || wb_stb_i) begin
                        r_grant_wb <= w_grant_wb;
                        r_last_wb  <= w_grant_wb;
                        r_we       <= w_grant_wb ? wb_we_i : dma_we;
                        r_wdata    <= w_grant_wb ? wb_dat_i : dma_wdata;
                        r_valid    <= w_in_range;
                        r_idx      <= w_idx;
                        r_wait_cnt <= '0;
                        r_state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_ACCESS: r_state <= ST_ACK;
                ST_ACK: begin
                    // A requester that gave up before completion gets neither ack nor write
                    if (w_req_held) begin
                        r_state <= ST_RECOVER;
                        if (r_grant_wb) begin
                            r_wb_ack <= 1'b1;
                            r_wb_dat <= w_rd_value;
                        end else begin
                            r_dma_ack   <= 1'b1;
                            r_dma_err   <= !r_valid;
                            r_dma_rdata <= w_rd_value;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign dma_ack   = r_dma_ack;
    assign dma_err   = r_dma_err;
    assign dma_rdata = r_dma_rdata;
    assign wb_ack_o  = r_wb_ack;
    assign wb_dat_o  = r_wb_dat;

endmodule
